// File: rtl/wshb_slave_pkg.sv
// Shared types and constants for the Wishbone classic slave memory.
// FSM encodings are plain localparam constants; the enum reuses them.
package wshb_slave_pkg;

    localparam int BYTE_W     = 8;
    localparam int WAIT_CNT_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        WAIT = ST_WAIT,
        RESP = ST_RESP
    } state_e;

    typedef enum logic [1:0] {
        RSP_ACK = 2'd0,
        RSP_ERR = 2'd1,
        RSP_RTY = 2'd2
    } resp_e;

endpackage

// File: rtl/wshb_slave_mem_if.sv
// Wishbone B3 classic-cycle bus bundle between a master and wshb_slave_mem.
// Signal names are from the slave's point of view.
interface wshb_slave_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] adr_i;
    logic [DATA_WIDTH-1:0] dat_i;
    logic                  cyc_i;
    logic                  stb_i;
    logic [SEL_WIDTH-1:0]  sel_i;
    logic                  we_i;
    logic                  busy_i;
    logic [DATA_WIDTH-1:0] dat_o;
    logic                  ack_o;
    logic                  err_o;
    logic                  rty_o;

    modport master (
        output adr_i, dat_i, cyc_i, stb_i, sel_i, we_i, busy_i,
        input  dat_o, ack_o, err_o, rty_o
    );

    modport slave (
        input  adr_i, dat_i, cyc_i, stb_i, sel_i, we_i, busy_i,
        output dat_o, ack_o, err_o, rty_o
    );

endinterface

// File: rtl/wshb_byte_ram.sv
// Single-port word RAM with per-byte write enables, synchronous write and
// combinational read. Contents are never reset.
module wshb_byte_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                         clk,
    input  logic [DATA_WIDTH/8-1:0]      be,
    input  logic [$clog2(MEM_DEPTH)-1:0] addr,
    input  logic [DATA_WIDTH-1:0]        wdata,
    output logic [DATA_WIDTH-1:0]        rdata
);
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < DATA_WIDTH / 8; i++) begin
            if (be[i]) begin
                mem_q[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/wshb_slave_mem.sv
// Wishbone B3 classic slave fronting a byte-lane RAM: programmable wait
// states, address-range error response and externally forced retry.
module wshb_slave_mem
    import wshb_slave_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    MEM_DEPTH   = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    wshb_slave_mem_if.slave bus
);
    localparam int SEL_WIDTH = DATA_WIDTH / BYTE_W;
    localparam int LANE_BITS = $clog2(SEL_WIDTH);
    localparam int RAM_AW    = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(MEM_DEPTH * SEL_WIDTH);

    state_e                  state_q, state_d;
    resp_e                   resp_q, resp_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [DATA_WIDTH-1:0]   wdat_q, wdat_d;
    logic [SEL_WIDTH-1:0]    sel_q, sel_d;
    logic                    we_q, we_d;
    logic                    busy_q, busy_d;
    logic                    ack_q, ack_d;
    logic                    err_q, err_d;
    logic                    rty_q, rty_d;
    logic [DATA_WIDTH-1:0]   rdat_q, rdat_d;

    logic [ADDR_WIDTH-1:0]   adr_off;
    logic                    in_range;
    logic [SEL_WIDTH-1:0]    ram_be;
    logic [DATA_WIDTH-1:0]   ram_rdata;

    // Offset is compared one bit wider so a window ending at the top of the address space still works.
    assign adr_off  = adr_q - BASE_ADDR;
    assign in_range = (adr_q >= BASE_ADDR) && ({1'b0, adr_off} < SPAN);

    // The write commits on the edge that closes the RESP cycle, so a reset before then discards it.
    assign ram_be = (state_q == RESP && resp_q == RSP_ACK && we_q) ? sel_q : '0;

    wshb_byte_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_ram (
        .clk   (clk),
        .be    (ram_be),
        .addr  (adr_off[LANE_BITS +: RAM_AW]),
        .wdata (wdat_q),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        resp_d  = resp_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        busy_d  = busy_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rty_d   = 1'b0;
        rdat_d  = '0;

        case (state_q)
            IDLE: begin
                if (bus.cyc_i && bus.stb_i) begin
                    adr_d   = bus.adr_i;
                    wdat_d  = bus.dat_i;
                    sel_d   = bus.sel_i;
                    we_d    = bus.we_i;
                    busy_d  = bus.busy_i;
                    cnt_d   = WAIT_CNT_W'(WAIT_STATES);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!bus.cyc_i) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = RESP;
                    if (busy_q) begin
                        resp_d = RSP_RTY;
                        rty_d  = 1'b1;
                    end else if (!in_range) begin
                        resp_d = RSP_ERR;
                        err_d  = 1'b1;
                    end else begin
                        resp_d = RSP_ACK;
                        ack_d  = 1'b1;
                        rdat_d = we_q ? '0 : ram_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            resp_q  <= RSP_ACK;
            cnt_q   <= '0;
            adr_q   <= '0;
            wdat_q  <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rty_q   <= 1'b0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            resp_q  <= resp_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rty_q   <= rty_d;
            rdat_q  <= rdat_d;
        end
    end

    assign bus.dat_o = rdat_q;
    assign bus.ack_o = ack_q;
    assign bus.err_o = err_q;
    assign bus.rty_o = rty_q;

endmodule

// File: tb/tb_wshb_slave_mem.sv
// Directed bench for wshb_slave_mem: one instance with no wait states and one
// with three, sharing a master whose cyc/stb are steered to the selected target.
module tb_wshb_slave_mem;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] m_adr  = '0;
    logic [31:0] m_wdat = '0;
    logic [3:0]  m_sel  = '0;
    logic        m_we   = 1'b0;
    logic        m_busy = 1'b0;
    logic        m_cyc  = 1'b0;
    logic        m_stb  = 1'b0;
    logic        tgt3   = 1'b0;

    wshb_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
    wshb_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus3 ();

    assign bus0.adr_i  = m_adr;
    assign bus0.dat_i  = m_wdat;
    assign bus0.sel_i  = m_sel;
    assign bus0.we_i   = m_we;
    assign bus0.busy_i = m_busy;
    assign bus0.cyc_i  = m_cyc & ~tgt3;
    assign bus0.stb_i  = m_stb & ~tgt3;
    assign bus3.adr_i  = m_adr;
    assign bus3.dat_i  = m_wdat;
    assign bus3.sel_i  = m_sel;
    assign bus3.we_i   = m_we;
    assign bus3.busy_i = m_busy;
    assign bus3.cyc_i  = m_cyc & tgt3;
    assign bus3.stb_i  = m_stb & tgt3;

    wshb_slave_mem #(.WAIT_STATES(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    wshb_slave_mem #(.WAIT_STATES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    logic [31:0] r_dat;
    logic        r_ack, r_err, r_rty;
    assign r_dat = tgt3 ? bus3.dat_o : bus0.dat_o;
    assign r_ack = tgt3 ? bus3.ack_o : bus0.ack_o;
    assign r_err = tgt3 ? bus3.err_o : bus0.err_o;
    assign r_rty = tgt3 ? bus3.rty_o : bus0.rty_o;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // rsp is {ack,err,rty}; lat counts edges from the request-sample edge to the response.
    task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic w, input logic b,
                        output logic [31:0] rd, output logic [2:0] rsp, output int lat);
        lat = 0;
        rsp = '0;
        rd  = '0;
        @(posedge clk); #1;
        m_adr = a; m_wdat = d; m_sel = s; m_we = w; m_busy = b;
        m_cyc = 1'b1; m_stb = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk); #1;
            if (r_ack || r_err || r_rty) begin
                lat = k;
                rsp = {r_ack, r_err, r_rty};
                rd  = r_dat;
                break;
            end
        end
        m_cyc = 1'b0; m_stb = 1'b0; m_busy = 1'b0;
        if (lat == 0) begin
            chk("timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk); #1;
            chk("resp_one_cycle", {29'b0, r_ack, r_err, r_rty}, 32'd0);
            chk("dat_after_resp", r_dat, 32'd0);
        end
    endtask

    logic [31:0] rd;
    logic [2:0]  rsp;
    int          lat;
    int          seen;

    initial begin
        #2;
        chk("rst_ack0", {31'b0, bus0.ack_o}, 32'd0);
        chk("rst_err0", {31'b0, bus0.err_o}, 32'd0);
        chk("rst_rty0", {31'b0, bus0.rty_o}, 32'd0);
        chk("rst_dat0", bus0.dat_o, 32'd0);
        chk("rst_rsp3", {29'b0, bus3.ack_o, bus3.err_o, bus3.rty_o}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Zero wait states: full-word write and read back.
        xfer(32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, rd, rsp, lat);
        chk("wr10_rsp", {29'b0, rsp}, 32'b100);
        chk("wr10_lat", lat, 32'd1);
        xfer(32'h10, 32'h0, 4'hF, 1'b0, 1'b0, rd, rsp, lat);
        chk("rd10_rsp", {29'b0, rsp}, 32'b100);
        chk("rd10_lat", lat, 32'd1);
        chk("rd10_dat", rd, 32'hDEADBEEF);
        xfer(32'h13, 32'h0, 4'h1, 1'b0, 1'b0, rd, rsp, lat);
        chk("rd13_lowbits", rd, 32'hDEADBEEF);

        // Byte lanes: only lanes 0 and 2 take the second write.
        xfer(32'h20, 32'h11223344, 4'hF, 1'b1, 1'b0, rd, rsp, lat);
        xfer(32'h20, 32'hAABBCCDD, 4'h5, 1'b1, 1'b0, rd, rsp, lat);
        xfer(32'h20, 32'h0, 4'h0, 1'b0, 1'b0, rd, rsp, lat);
        chk("rd20_lanes", rd, 32'h11BB33DD);

        // Range: last word in range acks; first word past the end errors and writes nothing.
        xfer(32'h0, 32'h0000CAFE, 4'hF, 1'b1, 1'b0, rd, rsp, lat);
        xfer(32'hFFC, 32'h5A5A5A5A, 4'hF, 1'b1, 1'b0, rd, rsp, lat);
        chk("wrffc_rsp", {29'b0, rsp}, 32'b100);
        xfer(32'hFFC, 32'h0, 4'hF, 1'b0, 1'b0, rd, rsp, lat);
        chk("rdffc_dat", rd, 32'h5A5A5A5A);
        xfer(32'h1000, 32'h12345678, 4'hF, 1'b1, 1'b0, rd, rsp, lat);
        chk("wr1000_rsp", {29'b0, rsp}, 32'b010);
        xfer(32'h1000, 32'h0, 4'hF, 1'b0, 1'b0, rd, rsp, lat);
        chk("rd1000_rsp", {29'b0, rsp}, 32'b010);
        chk("rd1000_dat", rd, 32'h0);
        xfer(32'h0, 32'h0, 4'hF, 1'b0, 1'b0, rd, rsp, lat);
        chk("rd0_unchanged", rd, 32'h0000CAFE);

        // Forced retry beats everything, returns no data and never writes.
        xfer(32'h10, 32'h0, 4'hF, 1'b0, 1'b1, rd, rsp, lat);
        chk("rty_rd_rsp", {29'b0, rsp}, 32'b001);
        chk("rty_rd_dat", rd, 32'h0);
        xfer(32'h2000, 32'h0, 4'hF, 1'b0, 1'b1, rd, rsp, lat);
        chk("rty_over_err", {29'b0, rsp}, 32'b001);
        xfer(32'h10, 32'h87654321, 4'hF, 1'b1, 1'b1, rd, rsp, lat);
        chk("rty_wr_rsp", {29'b0, rsp}, 32'b001);
        xfer(32'h10, 32'h0, 4'hF, 1'b0, 1'b0, rd, rsp, lat);
        chk("after_rty_rsp", {29'b0, rsp}, 32'b100);
        chk("after_rty_dat", rd, 32'hDEADBEEF);

        // Reset during WAIT of a write discards it.
        xfer(32'h30, 32'h0BADF00D, 4'hF, 1'b1, 1'b0, rd, rsp, lat);
        @(posedge clk); #1;
        m_adr = 32'h30; m_wdat = 32'h77777777; m_sel = 4'hF; m_we = 1'b1;
        m_cyc = 1'b1; m_stb = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_wait_rsp", {29'b0, r_ack, r_err, r_rty}, 32'd0);
        m_cyc = 1'b0; m_stb = 1'b0;
        @(posedge clk); #1;
        chk("rst_hold_rsp", {29'b0, r_ack, r_err, r_rty}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        xfer(32'h30, 32'h0, 4'hF, 1'b0, 1'b0, rd, rsp, lat);
        chk("rd30_prior", rd, 32'h0BADF00D);

        // Reset while ack is high clears outputs without waiting for a clock.
        @(posedge clk); #1;
        m_adr = 32'h10; m_we = 1'b0; m_cyc = 1'b1; m_stb = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_ack", {31'b0, r_ack}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_ack", {31'b0, r_ack}, 32'd0);
        chk("async_rst_dat", r_dat, 32'd0);
        m_cyc = 1'b0; m_stb = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Three wait states.
        tgt3 = 1'b1;
        xfer(32'h40, 32'hA5A5A5A5, 4'hF, 1'b1, 1'b0, rd, rsp, lat);
        chk("ws3_wr_rsp", {29'b0, rsp}, 32'b100);
        chk("ws3_wr_lat", lat, 32'd4);
        xfer(32'h40, 32'h0, 4'hF, 1'b0, 1'b0, rd, rsp, lat);
        chk("ws3_rd_lat", lat, 32'd4);
        chk("ws3_rd_dat", rd, 32'hA5A5A5A5);

        // Abort in WAIT: no response, no write.
        @(posedge clk); #1;
        m_adr = 32'h40; m_wdat = 32'hFFFFFFFF; m_sel = 4'hF; m_we = 1'b1;
        m_cyc = 1'b1; m_stb = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_cyc = 1'b0; m_stb = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (r_ack || r_err || r_rty) seen++;
        end
        chk("abort_resp", seen, 32'd0);
        xfer(32'h40, 32'h0, 4'hF, 1'b0, 1'b0, rd, rsp, lat);
        chk("abort_no_write", rd, 32'hA5A5A5A5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
